// File: rtl/fp_mul_pkg.sv
// Shared types and format helpers for the floating-point multiplier.
// FPMUL_INF_NAN_EN selects IEEE Inf/NaN handling and changes EMAX.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ROUND,
    DONE
  } state_t;

  function automatic int ework_w(input int exp_w);
    return exp_w + 2;
  endfunction

  function automatic int prod_w(input int man_w);
    return 2 * man_w + 2;
  endfunction

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int emax_of(input int exp_w);
`ifdef FPMUL_INF_NAN_EN
    return (1 << exp_w) - 2;
`else
    return (1 << exp_w) - 1;
`endif
  endfunction

  function automatic logic [63:0] qnan_of(
    input int exp_w,
    input int man_w
  );
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/float_multiplier_pipe_if.sv
// Operand/result handshake bundle for float_multiplier_pipe.
// master = operand source and result sink, slave = multiplier.
interface float_multiplier_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         overflow;
  logic         underflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y,
    input  overflow, underflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y,
    output overflow, underflow
  );
endinterface

// File: rtl/fp_round_rne.sv
// Normalise, round-to-nearest-even and range check of a raw product.
// FPMUL_INF_NAN_EN turns saturation into signed infinity.
module fp_round_rne
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int W  = 1 + EXP_W + MAN_W,
  localparam int EW = ework_w(EXP_W),
  localparam int PW = prod_w(MAN_W)
) (
  input  logic                 sign,
  input  logic [PW-1:0]        prod,
  input  logic signed [EW-1:0] e,
  output logic [W-1:0]         y,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic signed [EW-1:0] EMAX =
    EW'(emax_of(EXP_W));
  localparam logic signed [EW-1:0] ONE = EW'(1);

  logic [PW-2:0]         sh;
  logic [MAN_W-1:0]      man;
  logic [MAN_W-1:0]      man_r;
  logic                  rb;
  logic                  sb;
  logic                  inc;
  logic                  cy;
  logic signed [EW-1:0]  e_n;
  logic signed [EW-1:0]  e_r;

  always_comb begin
    // Drop the leading one; product is in [1,4)
    sh  = prod[PW-1] ? prod[PW-2:0]
                     : {prod[PW-3:0], 1'b0};
    e_n = prod[PW-1] ? e + ONE : e;
    man = sh[PW-2 -: MAN_W];
    rb  = sh[PW-2-MAN_W];
    sb  = |sh[PW-3-MAN_W:0];
    inc = rb & (sb | man[0]);
    {cy, man_r} = {1'b0, man}
                + {{MAN_W{1'b0}}, inc};
    e_r = cy ? e_n + ONE : e_n;

    y         = {sign, e_r[EXP_W-1:0], man_r};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (e_r <= 0) begin
      y         = {sign, {(W-1){1'b0}}};
      underflow = 1'b1;
    end else if (e_r > EMAX) begin
      overflow = 1'b1;
`ifdef FPMUL_INF_NAN_EN
      y = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
      y = {sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
`endif
    end
  end

endmodule

// File: rtl/float_multiplier_pipe.sv
// Multi-cycle EXP_W/MAN_W float multiplier, RNE, flush-to-zero.
// FPMUL_INF_NAN_EN enables Inf/NaN operands and infinite overflow.
module float_multiplier_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  float_multiplier_pipe_if.slave bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = ework_w(EXP_W);
  localparam int PW = prod_w(MAN_W);
  localparam logic signed [EW-1:0] BIAS_E =
    EW'(bias_of(EXP_W));

  state_t               state;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic [PW-1:0]        prod_q;
  logic signed [EW-1:0] e_q;
  logic                 sign_q;
  logic                 zero_q;
  logic [W-1:0]         y_q;
  logic                 of_q;
  logic                 uf_q;
  logic                 vld_q;

  logic [EXP_W-1:0]     ea;
  logic [EXP_W-1:0]     eb;
  logic [MAN_W-1:0]     ma;
  logic [MAN_W-1:0]     mb;
  logic [PW-1:0]        prod_c;
  logic signed [EW-1:0] e_c;
  logic                 zero_c;
  logic [W-1:0]         y_rnd;
  logic                 of_rnd;
  logic                 uf_rnd;
  logic [W-1:0]         y_c;
  logic                 of_c;
  logic                 uf_c;

  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign ma = a_q[MAN_W-1:0];
  assign mb = b_q[MAN_W-1:0];

  assign prod_c = {{(MAN_W+1){1'b0}}, 1'b1, ma}
                * {{(MAN_W+1){1'b0}}, 1'b1, mb};
  assign e_c    = $signed({2'b00, ea})
                + $signed({2'b00, eb}) - BIAS_E;
  assign zero_c = (ea == '0) | (eb == '0);

`ifdef FPMUL_INF_NAN_EN
  localparam logic [W-1:0] QNAN =
    W'(qnan_of(EXP_W, MAN_W));

  logic nan_q;
  logic inf_q;
  logic a_nan;
  logic b_nan;
  logic a_inf;
  logic b_inf;
  logic nan_c;
  logic inf_c;

  assign a_nan = (&ea) & (|ma);
  assign b_nan = (&eb) & (|mb);
  assign a_inf = (&ea) & ~(|ma);
  assign b_inf = (&eb) & ~(|mb);
  assign nan_c = a_nan | b_nan
               | (a_inf & (eb == '0))
               | (b_inf & (ea == '0));
  assign inf_c = (a_inf | b_inf) & ~nan_c;
`endif

  fp_round_rne #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_rnd (
    .sign     (sign_q),
    .prod     (prod_q),
    .e        (e_q),
    .y        (y_rnd),
    .overflow (of_rnd),
    .underflow(uf_rnd)
  );

  // Specials override the rounder; later checks win
  always_comb begin
    y_c  = y_rnd;
    of_c = of_rnd;
    uf_c = uf_rnd;
    if (zero_q) begin
      y_c  = {sign_q, {(W-1){1'b0}}};
      of_c = 1'b0;
      uf_c = 1'b0;
    end
`ifdef FPMUL_INF_NAN_EN
    if (inf_q) begin
      y_c  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      of_c = 1'b0;
      uf_c = 1'b0;
    end
    if (nan_q) begin
      y_c  = QNAN;
      of_c = 1'b0;
      uf_c = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      e_q    <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef FPMUL_INF_NAN_EN
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
`endif
      y_q    <= '0;
      of_q   <= 1'b0;
      uf_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            state <= MUL;
          end
        end
        MUL: begin
          prod_q <= prod_c;
          e_q    <= e_c;
          sign_q <= a_q[W-1] ^ b_q[W-1];
          zero_q <= zero_c;
`ifdef FPMUL_INF_NAN_EN
          nan_q  <= nan_c;
          inf_q  <= inf_c;
`endif
          state  <= ROUND;
        end
        ROUND: begin
          y_q   <= y_c;
          of_q  <= of_c;
          uf_q  <= uf_c;
          vld_q <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = vld_q;
  assign bus.y         = y_q;
  assign bus.overflow  = of_q;
  assign bus.underflow = uf_q;

endmodule
